// File: rtl/pito_mvu_arbiter_pkg.sv
// Shared constants and types for the MVU arbiter: hart count, command width,
// MVU interrupt line number and the arbiter FSM state encoding.
package pito_mvu_arbiter_pkg;

    localparam int NUM_HARTS      = 8;
    localparam int HART_CNT_WIDTH = $clog2(NUM_HARTS);
    localparam int XPR_LEN        = 32;
    localparam int IRQ_MVU_INTR   = 16;

    typedef enum logic [1:0] {
        MVU_ARB_IDLE  = 2'd0,
        MVU_ARB_START = 2'd1,
        MVU_ARB_RUN   = 2'd2
    } mvu_arb_state_t;

endpackage

// File: rtl/pito_rr_picker.sv
// Combinational round-robin picker: returns the first eligible hart found
// when searching upward from rr_ptr, wrapping at NUM_HARTS.
module pito_rr_picker #(
    parameter int NUM_HARTS      = 8,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
    input  logic [NUM_HARTS-1:0]      eligible,
    input  logic [HART_CNT_WIDTH-1:0] rr_ptr,
    output logic                      found,
    output logic [HART_CNT_WIDTH-1:0] winner
);

    localparam int IW = HART_CNT_WIDTH + 1;

    logic [IW-1:0] idx_s;

    // Walk the offsets from farthest to nearest so the hart closest to rr_ptr overwrites the rest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_s  = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            idx_s = IW'(rr_ptr) + IW'(i);
            if (idx_s >= IW'(NUM_HARTS)) begin
                idx_s = idx_s - IW'(NUM_HARTS);
            end else begin
                idx_s = idx_s;
            end
            if (eligible[idx_s[HART_CNT_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = idx_s[HART_CNT_WIDTH-1:0];
            end else begin
                found  = found;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/pito_mvu_arbiter.sv
// Round-robin arbiter sharing one MVU among the barrel-processor harts; tracks
// the running job and raises the owner's MVU interrupt-pending bit on completion.
module pito_mvu_arbiter #(
    parameter int NUM_HARTS      = 8,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
    parameter int CMD_W          = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_HARTS-1:0]         req_i,
    input  logic [NUM_HARTS*CMD_W-1:0]   cmd_i,
    output logic [NUM_HARTS-1:0]         gnt_o,
    output logic                         mvu_start_o,
    output logic [CMD_W-1:0]             mvu_cmd_o,
    output logic [HART_CNT_WIDTH-1:0]    mvu_owner_o,
    input  logic                         mvu_done_i,
    output logic                         busy_o,
    output logic [NUM_HARTS-1:0]         irq_o,
    input  logic [NUM_HARTS-1:0]         irq_ack_i
);

    import pito_mvu_arbiter_pkg::*;

    mvu_arb_state_t              state_r;
    mvu_arb_state_t              state_s;
    logic [HART_CNT_WIDTH-1:0]   rr_ptr_r;
    logic [HART_CNT_WIDTH-1:0]   rr_ptr_s;
    logic [HART_CNT_WIDTH-1:0]   owner_r;
    logic [HART_CNT_WIDTH-1:0]   owner_s;
    logic [HART_CNT_WIDTH-1:0]   winner_s;
    logic                        found_s;
    logic [NUM_HARTS-1:0]        eligible_s;
    logic [NUM_HARTS-1:0]        gnt_r;
    logic [NUM_HARTS-1:0]        gnt_s;
    logic [NUM_HARTS-1:0]        irq_r;
    logic [NUM_HARTS-1:0]        irq_s;
    logic [NUM_HARTS-1:0]        irq_set_s;
    logic                        start_r;
    logic                        start_s;
    logic                        busy_r;
    logic                        busy_s;
    logic                        done_s;
    logic [CMD_W-1:0]            cmd_r;
    logic [CMD_W-1:0]            cmd_s;

    // A hart whose completion is still unacknowledged cannot win, so no interrupt is overwritten.
    assign eligible_s = req_i & ~irq_r;

    pito_rr_picker #(
        .NUM_HARTS      (NUM_HARTS),
        .HART_CNT_WIDTH (HART_CNT_WIDTH)
    ) u_picker (
        .eligible (eligible_s),
        .rr_ptr   (rr_ptr_r),
        .found    (found_s),
        .winner   (winner_s)
    );

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_s   = state_r;
        rr_ptr_s  = rr_ptr_r;
        owner_s   = owner_r;
        cmd_s     = cmd_r;
        gnt_s     = '0;
        start_s   = 1'b0;
        busy_s    = busy_r;
        done_s    = 1'b0;
        irq_set_s = '0;

        case (state_r)
            MVU_ARB_IDLE: begin
                if (found_s) begin
                    owner_s  = winner_s;
                    cmd_s    = cmd_i[winner_s*CMD_W +: CMD_W];
                    rr_ptr_s = (winner_s == HART_CNT_WIDTH'(NUM_HARTS - 1))
                             ? '0 : winner_s + HART_CNT_WIDTH'(1);
                    gnt_s    = NUM_HARTS'(1) << winner_s;
                    start_s  = 1'b1;
                    busy_s   = 1'b1;
                    state_s  = MVU_ARB_START;
                end else begin
                    state_s  = MVU_ARB_IDLE;
                    busy_s   = 1'b0;
                end
            end
            MVU_ARB_START, MVU_ARB_RUN: begin
                if (mvu_done_i) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = MVU_ARB_IDLE;
                end else begin
                    busy_s  = 1'b1;
                    state_s = MVU_ARB_RUN;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = MVU_ARB_IDLE;
            end
        endcase

        if (done_s) begin
            irq_set_s = NUM_HARTS'(1) << owner_r;
        end else begin
            irq_set_s = '0;
        end
        // A completion landing in the same cycle as an acknowledge keeps the bit set.
        irq_s = (irq_r & ~irq_ack_i) | irq_set_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= MVU_ARB_IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            cmd_r    <= '0;
            gnt_r    <= '0;
            start_r  <= 1'b0;
            busy_r   <= 1'b0;
            irq_r    <= '0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            owner_r  <= owner_s;
            cmd_r    <= cmd_s;
            gnt_r    <= gnt_s;
            start_r  <= start_s;
            busy_r   <= busy_s;
            irq_r    <= irq_s;
        end
    end

    assign gnt_o       = gnt_r;
    assign mvu_start_o = start_r;
    assign mvu_cmd_o   = cmd_r;
    assign mvu_owner_o = owner_r;
    assign busy_o      = busy_r;
    assign irq_o       = irq_r;

endmodule

// File: tb/tb_pito_mvu_arbiter.sv
// Directed bench for pito_mvu_arbiter: expected grants are queued when requests
// are driven and compared when the MVU start pulse appears.
module tb_pito_mvu_arbiter;

    localparam int NH = 8;
    localparam int HW = 3;
    localparam int CW = 32;

    typedef struct packed {
        logic [HW-1:0] owner;
        logic [CW-1:0] cmd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NH-1:0]     req_i;
    logic [NH*CW-1:0]  cmd_i;
    logic [NH-1:0]     gnt_o;
    logic              mvu_start_o;
    logic [CW-1:0]     mvu_cmd_o;
    logic [HW-1:0]     mvu_owner_o;
    logic              mvu_done_i;
    logic              busy_o;
    logic [NH-1:0]     irq_o;
    logic [NH-1:0]     irq_ack_i;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pito_mvu_arbiter #(.NUM_HARTS(NH), .HART_CNT_WIDTH(HW), .CMD_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .cmd_i       (cmd_i),
        .gnt_o       (gnt_o),
        .mvu_start_o (mvu_start_o),
        .mvu_cmd_o   (mvu_cmd_o),
        .mvu_owner_o (mvu_owner_o),
        .mvu_done_i  (mvu_done_i),
        .busy_o      (busy_o),
        .irq_o       (irq_o),
        .irq_ack_i   (irq_ack_i)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int h, input logic [CW-1:0] c);
        exp_t e;
        e.owner = HW'(h);
        e.cmd   = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (mvu_start_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("start_seen", 64'(mvu_start_o), 64'd1);
    endtask

    task automatic grant_check();
        exp_t e;
        chk("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("gnt", 64'(gnt_o), 64'(8'd1 << e.owner));
            chk("owner", 64'(mvu_owner_o), 64'(e.owner));
            chk("cmd", 64'(mvu_cmd_o), 64'(e.cmd));
            chk("busy_at_start", 64'(busy_o), 64'd1);
        end
    endtask

    task automatic set_cmd(input int h, input logic [CW-1:0] c);
        cmd_i[h*CW +: CW] = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int prev;
        int h;

        rst_n      = 1'b0;
        req_i      = '0;
        cmd_i      = '0;
        mvu_done_i = 1'b0;
        irq_ack_i  = '0;
        tick();
        tick();
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_start", 64'(mvu_start_o), 64'd0);
        chk("rst_cmd", 64'(mvu_cmd_o), 64'd0);
        chk("rst_owner", 64'(mvu_owner_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_irq", 64'(irq_o), 64'd0);
        rst_n = 1'b1;

        // Single job for hart 2, done five cycles after start.
        req_i = 8'h04;
        set_cmd(2, 32'hA5A5_0001);
        push_exp(2, 32'hA5A5_0001);
        t0 = cyc;
        tick();
        wait_start(2);
        chk("t1_latency", 64'(cyc - t0), 64'd1);
        grant_check();
        req_i = 8'h00;
        tick();
        chk("t1_start_pulse", 64'(mvu_start_o), 64'd0);
        chk("t1_gnt_pulse", 64'(gnt_o), 64'd0);
        tick();
        tick();
        tick();
        tick();
        chk("t1_busy_run", 64'(busy_o), 64'd1);
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        chk("t1_irq", 64'(irq_o), 64'h04);
        chk("t1_busy_done", 64'(busy_o), 64'd0);
        irq_ack_i = 8'h04;
        tick();
        irq_ack_i = 8'h00;
        chk("t1_irq_ack", 64'(irq_o), 64'd0);

        // All harts requesting: strict rotation 0..7,0 with 5-cycle spacing.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NH; i++) set_cmd(i, 32'hC0DE_0000 | 32'(i));
        req_i = 8'hFF;
        prev  = 0;
        for (int k = 0; k < 9; k++) begin
            h = k % NH;
            push_exp(h, 32'hC0DE_0000 | 32'(h));
            wait_start(4);
            if (k > 0) chk("t2_spacing", 64'(cyc - prev), 64'd5);
            prev = cyc;
            irq_ack_i = 8'h00;
            grant_check();
            tick();
            tick();
            tick();
            mvu_done_i = 1'b1;
            tick();
            mvu_done_i = 1'b0;
            chk("t2_irq", 64'(irq_o), 64'(8'd1 << h));
            chk("t2_busy", 64'(busy_o), 64'd0);
            irq_ack_i = 8'd1 << h;
            if (k == 8) req_i = 8'h00;
            tick();
        end
        irq_ack_i = 8'h00;
        chk("t2_idle", 64'(busy_o), 64'd0);

        // Hart 3 with a pending interrupt is masked until acknowledged.
        req_i = 8'h08;
        set_cmd(3, 32'h3333_0003);
        push_exp(3, 32'h3333_0003);
        tick();
        wait_start(2);
        grant_check();
        req_i = 8'h00;
        tick();
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        chk("t3_irq", 64'(irq_o), 64'h08);
        req_i = 8'h08;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_masked_start", 64'(mvu_start_o), 64'd0);
            chk("t3_masked_busy", 64'(busy_o), 64'd0);
        end
        irq_ack_i = 8'h08;
        t0 = cyc;
        tick();
        irq_ack_i = 8'h00;
        chk("t3_irq_cleared", 64'(irq_o), 64'd0);
        push_exp(3, 32'h3333_0003);
        wait_start(3);
        chk("t3_regrant_latency", 64'(cyc - t0), 64'd2);
        grant_check();

        // Done during START skips RUN; done in IDLE is ignored.
        mvu_done_i = 1'b1;
        req_i = 8'h00;
        tick();
        mvu_done_i = 1'b0;
        chk("t4_irq", 64'(irq_o), 64'h08);
        chk("t4_busy", 64'(busy_o), 64'd0);
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        chk("t4_spur_busy", 64'(busy_o), 64'd0);
        chk("t4_spur_irq", 64'(irq_o), 64'h08);
        chk("t4_spur_owner", 64'(mvu_owner_o), 64'd3);
        chk("t4_spur_start", 64'(mvu_start_o), 64'd0);
        irq_ack_i = 8'h08;
        tick();
        irq_ack_i = 8'h00;

        // Completion and acknowledge on hart 5 in the same cycle: set wins.
        req_i = 8'h20;
        set_cmd(5, 32'h5555_0005);
        push_exp(5, 32'h5555_0005);
        tick();
        wait_start(2);
        grant_check();
        req_i = 8'h00;
        tick();
        mvu_done_i = 1'b1;
        irq_ack_i  = 8'h20;
        tick();
        mvu_done_i = 1'b0;
        irq_ack_i  = 8'h00;
        chk("t5_set_wins", 64'(irq_o), 64'h20);
        chk("t5_busy", 64'(busy_o), 64'd0);

        // Reset during RUN drops the job, the pending irq and the rotation pointer.
        req_i = 8'h02;
        set_cmd(1, 32'h1111_0001);
        push_exp(1, 32'h1111_0001);
        tick();
        wait_start(2);
        grant_check();
        req_i = 8'h00;
        tick();
        chk("t6_busy_run", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_gnt", 64'(gnt_o), 64'd0);
        chk("t6_start", 64'(mvu_start_o), 64'd0);
        chk("t6_cmd", 64'(mvu_cmd_o), 64'd0);
        chk("t6_owner", 64'(mvu_owner_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_irq", 64'(irq_o), 64'd0);
        req_i = 8'h82;
        set_cmd(7, 32'h7777_0007);
        push_exp(1, 32'h1111_0001);
        tick();
        wait_start(2);
        grant_check();
        req_i = 8'h00;
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        chk("t6_irq_after", 64'(irq_o), 64'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
